// File: rtl/taxi_fare_engine_pkg.sv
// Shared types and helpers for the taximeter fare core.
package taxi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2
   } taxi_state_t;

   // Largest fare representable in the given number of decimal digits.
   function automatic int calc_max_fare(input int digits);
      int m;
      m = 1;
      for (int i = 0; i < digits; i++) m = m * 10;
      return m - 1;
   endfunction

endpackage

// File: rtl/taxi_fare_engine_if.sv
// Trip controls and fare results shared between the fare core and its user.
interface taxi_fare_engine_if #(
   parameter int DIGITS = 4,
   parameter int FARE_W = 4 * DIGITS
);
   logic                  start;
   logic                  pause;
   logic                  night;
   logic [2:0]            speed;
   logic                  meter_on;
   logic                  tick;
   logic [FARE_W-1:0]     fare_bin;
   logic [4*DIGITS-1:0]   fare_bcd;
   logic                  bcd_valid;
   logic                  busy;

   modport master (
      output start, pause, night, speed,
      input  meter_on, tick, fare_bin, fare_bcd, bcd_valid, busy
   );

   modport slave (
      input  start, pause, night, speed,
      output meter_on, tick, fare_bin, fare_bcd, bcd_valid, busy
   );
endinterface

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter: one shift plus add-3 per cycle, W cycles.
// The bcd output only changes on completion, so it never shows a partial value.
module bin2bcd_seq #(
   parameter int W      = 16,
   parameter int DIGITS = 4
) (
   input  logic                clk_50MHz,
   input  logic                rst,
   input  logic                go,
   input  logic [W-1:0]        bin,
   output logic                busy,
   output logic                done,
   output logic [4*DIGITS-1:0] bcd
);
   localparam int CW = $clog2(W + 1);

   logic [W-1:0]        sh;
   logic [4*DIGITS-1:0] acc, acc_adj, acc_nxt;
   logic [CW-1:0]       cnt;

   // one double-dabble step: add 3 to digits >= 5, then shift in the next bit
   always_comb begin
      acc_adj = acc;
      for (int d = 0; d < DIGITS; d++)
         if (acc[4*d +: 4] >= 4'd5) acc_adj[4*d +: 4] = acc[4*d +: 4] + 4'd3;
      acc_nxt = {acc_adj[4*DIGITS-2:0], sh[W-1]};
   end

   // launch, step and publish the conversion
   always_ff @(posedge clk_50MHz) begin
      if (rst) begin
         busy <= 1'b0;
         done <= 1'b0;
         bcd  <= '0;
         acc  <= '0;
         sh   <= '0;
         cnt  <= '0;
      end else begin
         done <= 1'b0;
         if (busy) begin
            acc <= acc_nxt;
            sh  <= {sh[W-2:0], 1'b0};
            cnt <= cnt + CW'(1);
            if (cnt == CW'(W - 1)) begin
               busy <= 1'b0;
               done <= 1'b1;
               bcd  <= acc_nxt;
            end
         end else if (go) begin
            sh   <= bin;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
         end
      end
   end
endmodule

// File: rtl/taxi_fare_engine.sv
// Taximeter fare core: tick divider, IDLE/RUN/PAUSE metering, floor and
// saturation, and a BCD view of the charged fare.
module taxi_fare_engine
   import taxi_pkg::*;
#(
   parameter int CLK_HZ     = 50000000,
   parameter int TICK_HZ    = 1,
   parameter int DIGITS     = 4,
   parameter int FARE_W     = 4 * DIGITS,
   parameter int START_FARE = 30,
   parameter int WAIT_TICKS = 5,
   parameter int WAIT_RATE  = 1
) (
   input  logic              clk_50MHz,
   input  logic              rst,
   taxi_fare_engine_if.slave bus
);
   localparam int DIV      = CLK_HZ / TICK_HZ;
   localparam int DIV_W    = $clog2(DIV);
   localparam int MAX_FARE = calc_max_fare(DIGITS);
   localparam int WC_W     = $clog2(WAIT_TICKS + 1);
   localparam int SUM_W    = FARE_W + 1;

   taxi_state_t         state;
   logic [DIV_W-1:0]    div_cnt;
   logic                tick;
   logic [FARE_W-1:0]   meter, fare_bin, last_bin, meter_sat;
   logic [WC_W-1:0]     wait_cnt;
   logic                meter_on;
   logic [SUM_W-1:0]    inc, sum;
   logic                conv_go, conv_busy, conv_done;
   logic [4*DIGITS-1:0] conv_bcd;

   // free-running divider; wraps right after the terminal (tick) cycle
   always_ff @(posedge clk_50MHz) begin
      if (rst || tick) div_cnt <= '0;
      else             div_cnt <= div_cnt + DIV_W'(1);
   end
   assign tick = (div_cnt == DIV_W'(DIV - 1));

   // this tick's increment (distance or waiting charge) and the clamped sum
   always_comb begin
      if (bus.speed != 3'd0) inc = SUM_W'(bus.speed) << bus.night;
      else                   inc = SUM_W'(WAIT_RATE) << bus.night;
      sum       = {1'b0, meter} + inc;
      meter_sat = (sum > SUM_W'(MAX_FARE)) ? FARE_W'(MAX_FARE) : sum[FARE_W-1:0];
   end

   // trip state machine with metering; start low clears the trip first
   always_ff @(posedge clk_50MHz) begin
      if (rst || !bus.start) begin
         state    <= IDLE;
         meter    <= '0;
         wait_cnt <= '0;
         meter_on <= 1'b0;
      end else begin
         // the registered state decides, so a tick coinciding with pause rising counts
         if (state == RUN && tick) begin
            if (bus.speed != 3'd0) begin
               meter    <= meter_sat;
               wait_cnt <= '0;
            end else if (wait_cnt == WC_W'(WAIT_TICKS - 1)) begin
               meter    <= meter_sat;
               wait_cnt <= '0;
            end else begin
               wait_cnt <= wait_cnt + WC_W'(1);
            end
         end
         meter_on <= 1'b1;
         case (state)
            IDLE:    state <= bus.pause ? PAUSE : RUN;
            RUN:     if (bus.pause)  state <= PAUSE;
            PAUSE:   if (!bus.pause) state <= RUN;
            default: begin
               state    <= IDLE;
               meter_on <= 1'b0;
            end
         endcase
      end
   end

   assign fare_bin = (state == IDLE) ? '0 :
                     (meter < FARE_W'(START_FARE)) ? FARE_W'(START_FARE) : meter;

   // relaunch whenever the converter is free and the fare moved since the last launch
   assign conv_go = !conv_busy && (fare_bin != last_bin);

   // value most recently handed to the converter; 0 after reset so idle fare stays quiet
   always_ff @(posedge clk_50MHz) begin
      if (rst)          last_bin <= '0;
      else if (conv_go) last_bin <= fare_bin;
   end

   bin2bcd_seq #(.W(FARE_W), .DIGITS(DIGITS)) u_bcd (
      .clk_50MHz (clk_50MHz),
      .rst       (rst),
      .go        (conv_go),
      .bin       (fare_bin),
      .busy      (conv_busy),
      .done      (conv_done),
      .bcd       (conv_bcd)
   );

   assign bus.meter_on  = meter_on;
   assign bus.tick      = tick;
   assign bus.fare_bin  = fare_bin;
   assign bus.fare_bcd  = conv_bcd;
   assign bus.bcd_valid = conv_done;
   assign bus.busy      = conv_busy;
endmodule
